// File: rtl/arf_sched_if.sv
// rtl/arf_sched_if.sv - sample/coefficient/result bus of the shared-resource ARF sequencer
// slave is the sequencer's view, master is the producer/consumer's view.
interface arf_sched_if #(
  parameter int W = 16
);
  logic signed [W-1:0] in_1;
  logic signed [W-1:0] in_2;
  logic signed [W-1:0] in_3;
  logic signed [W-1:0] in_4;
  logic signed [W-1:0] in_5;
  logic signed [W-1:0] in_6;
  logic signed [W-1:0] in_7;
  logic signed [W-1:0] in_8;
  logic signed [W-1:0] in_13;
  logic signed [W-1:0] in_14;
  logic                in_valid;
  logic                in_ready;
  logic                coef_we;
  logic [3:0]          coef_addr;
  logic signed [W-1:0] coef_data;
  logic                busy;
  logic signed [W-1:0] out_27;
  logic signed [W-1:0] out_28;
  logic                out_valid;
  logic                out_ready;

  modport slave (
    input  in_1, in_2, in_3, in_4, in_5, in_6, in_7, in_8, in_13, in_14,
    input  in_valid, coef_we, coef_addr, coef_data, out_ready,
    output in_ready, busy, out_27, out_28, out_valid
  );

  modport master (
    output in_1, in_2, in_3, in_4, in_5, in_6, in_7, in_8, in_13, in_14,
    output in_valid, coef_we, coef_addr, coef_data, out_ready,
    input  in_ready, busy, out_27, out_28, out_valid
  );
endinterface

// File: rtl/arf_sched.sv
// rtl/arf_sched.sv - ARF data-flow graph on one shared multiplier and one shared adder
// Fixed 18-step schedule; results of every operation live in r_v indexed by graph node number.
module arf_sched #(
  parameter int W    = 16,
  parameter int FRAC = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  arf_sched_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [4:0]          r_step;
  logic signed [W-1:0] r_in   [8];
  logic signed [W-1:0] r_in13;
  logic signed [W-1:0] r_in14;
  logic signed [W-1:0] r_coef [16];
  logic signed [W-1:0] r_v    [32];

  logic signed [W-1:0]   w_ma;
  logic signed [W-1:0]   w_mb;
  logic [4:0]            w_mdst;
  logic signed [2*W-1:0] w_prod;
  logic signed [W-1:0]   w_mres;
  logic signed [W-1:0]   w_aa;
  logic signed [W-1:0]   w_ab;
  logic [4:0]            w_adst;
  logic signed [W-1:0]   w_asum;
  logic                  w_accept;

  assign w_accept = (r_state == S_IDLE) && bus.in_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.in_valid) w_next = S_RUN;
      S_RUN:   if (r_step == 5'd18) w_next = S_DONE;
      S_DONE:  if (bus.out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_step <= '0;
    end else if (w_accept) begin
      r_step <= 5'd1;
    end else if (r_state == S_RUN && r_step != 5'd18) begin
      r_step <= r_step + 5'd1;
    end else begin
      r_step <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) r_in[i] <= '0;
      r_in13 <= '0;
      r_in14 <= '0;
    end else if (w_accept) begin
      r_in[0] <= bus.in_1;
      r_in[1] <= bus.in_2;
      r_in[2] <= bus.in_3;
      r_in[3] <= bus.in_4;
      r_in[4] <= bus.in_5;
      r_in[5] <= bus.in_6;
      r_in[6] <= bus.in_7;
      r_in[7] <= bus.in_8;
      r_in13  <= bus.in_13;
      r_in14  <= bus.in_14;
    end
  end

  // Writes land only in IDLE, which includes the accept edge itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) r_coef[i] <= '0;
    end else if (bus.coef_we && r_state == S_IDLE) begin
      r_coef[bus.coef_addr] <= bus.coef_data;
    end
  end

  always_comb begin
    w_ma   = '0;
    w_mb   = '0;
    w_mdst = '0;
    w_aa   = '0;
    w_ab   = '0;
    w_adst = '0;
    case (r_step)
      5'd1:  begin w_ma = r_in[0]; w_mb = r_coef[0]; w_mdst = 5'd1; end
      5'd2:  begin w_ma = r_in[1]; w_mb = r_coef[1]; w_mdst = 5'd2; end
      5'd3:  begin
        w_ma = r_in[2]; w_mb = r_coef[2]; w_mdst = 5'd3;
        w_aa = r_v[1];  w_ab = r_v[2];    w_adst = 5'd9;
      end
      5'd4:  begin
        w_ma = r_in[3]; w_mb = r_coef[3]; w_mdst = 5'd4;
        w_aa = r_v[9];  w_ab = r_in13;    w_adst = 5'd13;
      end
      5'd5:  begin
        w_ma = r_in[4]; w_mb = r_coef[4]; w_mdst = 5'd5;
        w_aa = r_v[3];  w_ab = r_v[4];    w_adst = 5'd10;
      end
      5'd6:  begin
        w_ma = r_in[5]; w_mb = r_coef[5]; w_mdst = 5'd6;
        w_aa = r_v[10]; w_ab = r_in14;    w_adst = 5'd14;
      end
      5'd7:  begin
        w_ma = r_in[6]; w_mb = r_coef[6]; w_mdst = 5'd7;
        w_aa = r_v[5];  w_ab = r_v[6];    w_adst = 5'd11;
      end
      5'd8:  begin w_ma = r_in[7]; w_mb = r_coef[7]; w_mdst = 5'd8; end
      5'd9:  begin
        w_ma = r_v[13]; w_mb = r_coef[8]; w_mdst = 5'd15;
        w_aa = r_v[7];  w_ab = r_v[8];    w_adst = 5'd12;
      end
      5'd10: begin w_ma = r_v[14]; w_mb = r_coef[9];  w_mdst = 5'd16; end
      5'd11: begin w_ma = r_v[13]; w_mb = r_coef[10]; w_mdst = 5'd17; end
      5'd12: begin
        w_ma = r_v[14]; w_mb = r_coef[11]; w_mdst = 5'd18;
        w_aa = r_v[15]; w_ab = r_v[16];    w_adst = 5'd19;
      end
      5'd13: begin
        w_ma = r_v[19]; w_mb = r_coef[12]; w_mdst = 5'd21;
        w_aa = r_v[17]; w_ab = r_v[18];    w_adst = 5'd20;
      end
      5'd14: begin w_ma = r_v[19]; w_mb = r_coef[13]; w_mdst = 5'd22; end
      5'd15: begin
        w_ma = r_v[20]; w_mb = r_coef[14]; w_mdst = 5'd23;
        w_aa = r_v[21]; w_ab = r_v[22];    w_adst = 5'd25;
      end
      5'd16: begin
        w_ma = r_v[20]; w_mb = r_coef[15]; w_mdst = 5'd24;
        w_aa = r_v[25]; w_ab = r_v[11];    w_adst = 5'd27;
      end
      5'd17: begin w_aa = r_v[23]; w_ab = r_v[24]; w_adst = 5'd26; end
      5'd18: begin w_aa = r_v[26]; w_ab = r_v[12]; w_adst = 5'd28; end
      default: ;
    endcase
  end

  // Arithmetic shift floors toward -inf; the cast keeps the low W bits.
  assign w_prod = w_ma * w_mb;
  assign w_mres = W'(w_prod >>> FRAC);
  assign w_asum = w_aa + w_ab;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) r_v[i] <= '0;
    end else if (r_state == S_RUN) begin
      if (w_mdst != 5'd0) r_v[w_mdst] <= w_mres;
      if (w_adst != 5'd0) r_v[w_adst] <= w_asum;
    end
  end

  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.busy      = (r_state == S_RUN) || (r_state == S_DONE);
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.out_27    = r_v[27];
  assign bus.out_28    = r_v[28];

endmodule

// File: tb/tb_arf_sched.sv
// tb/tb_arf_sched.sv - scoreboard bench for arf_sched
// Stimulus pushes expected {out_27,out_28}; a negedge monitor pops on each result handshake.
module tb_arf_sched;
  localparam int W = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  logic [2*W-1:0] exp_q [$];
  logic [2*W-1:0] mon_e;
  int   acc;
  int   t1;
  int   t2;
  bit   seen;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  arf_sched_if #(.W(W)) bus ();
  arf_sched #(.W(W), .FRAC(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got %0h/%0h expected none",
                 $unsigned(bus.out_27), $unsigned(bus.out_28));
      end else begin
        mon_e = exp_q.pop_front();
        chk("out_27", 32'($unsigned(bus.out_27)), 32'(mon_e[2*W-1:W]));
        chk("out_28", 32'($unsigned(bus.out_28)), 32'(mon_e[W-1:0]));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic set_inputs(input logic [W-1:0] v);
    bus.in_1 = v; bus.in_2 = v; bus.in_3 = v; bus.in_4 = v;
    bus.in_5 = v; bus.in_6 = v; bus.in_7 = v; bus.in_8 = v;
    bus.in_13 = v; bus.in_14 = v;
  endtask

  task automatic write_coef(input logic [3:0] a, input logic [W-1:0] d);
    bus.coef_we   = 1'b1;
    bus.coef_addr = a;
    bus.coef_data = d;
    @(posedge clk);
    #1;
    bus.coef_we = 1'b0;
  endtask

  task automatic load_all(input logic [W-1:0] d);
    for (int i = 0; i < 16; i++) write_coef(4'(i), d);
  endtask

  task automatic start_run(input logic [W-1:0] e27, input logic [W-1:0] e28,
                           input bit push, output int acc_cyc);
    bit ok;
    ok = 1'b0;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    chk("accept_seen", 32'(ok), 32'd1);
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    bus.in_valid = 1'b0;
    if (push) exp_q.push_back({e27, e28});
  endtask

  task automatic wait_valid(input int acc_cyc, input string tag);
    bit ok;
    bit rdy_low;
    ok = 1'b0;
    rdy_low = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        ok = 1'b1;
        break;
      end
      if (bus.in_ready || !bus.busy) rdy_low = 1'b0;
    end
    chk({tag, "_valid_seen"}, 32'(ok), 32'd1);
    chk({tag, "_latency"}, 32'(cyc - acc_cyc), 32'd18);
    chk({tag, "_in_ready_low"}, 32'(rdy_low && !bus.in_ready && bus.busy), 32'd1);
  endtask

  task automatic run_check(input logic [W-1:0] e27, input logic [W-1:0] e28, input string tag);
    int a;
    start_run(e27, e28, 1'b1, a);
    wait_valid(a, tag);
    @(negedge clk);
    chk({tag, "_idle_after"}, 32'({bus.in_ready, bus.out_valid, bus.busy}), 32'b100);
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.coef_we   = 1'b0;
    bus.coef_addr = '0;
    bus.coef_data = '0;
    set_inputs('0);
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_27", 32'($unsigned(bus.out_27)), 32'd0);
    chk("rst_out_28", 32'($unsigned(bus.out_28)), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Zero coefficients give zero regardless of the samples.
    set_inputs(16'd5);
    run_check(16'd0, 16'd0, "zero_coef");

    load_all(16'd256);
    set_inputs(16'd1);
    run_check(16'd14, 16'd14, "unit");

    load_all(16'd0);
    write_coef(4'd0, 16'd128);
    set_inputs(16'd1);
    bus.in_1 = -16'sd3; bus.in_13 = '0; bus.in_14 = '0;
    run_check(16'd0, 16'd0, "floor_m1");
    write_coef(4'd4, 16'd256);
    write_coef(4'd5, 16'd256);
    bus.in_5 = 16'sd7; bus.in_6 = -16'sd9;
    run_check(16'hFFFE, 16'd0, "neg_sum");

    // c1=2.0 in both runs; the write at E5 of the first run must be dropped.
    load_all(16'd256);
    write_coef(4'd0, 16'd512);
    set_inputs(16'd1);
    start_run(16'd16, 16'd16, 1'b1, acc);
    repeat (4) @(posedge clk);
    #1;
    write_coef(4'd0, 16'd0);
    wait_valid(acc, "busy_write_run1");
    @(posedge clk);
    #1;
    run_check(16'd16, 16'd16, "busy_write_run2");

    bus.out_ready = 1'b0;
    start_run(16'd16, 16'd16, 1'b1, acc);
    wait_valid(acc, "hold");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_stable", 32'({bus.out_valid, $unsigned(bus.out_27), $unsigned(bus.out_28)}),
          32'({1'b1, 16'd16, 16'd16}));
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("hold_release_idle", 32'({bus.in_ready, bus.out_valid}), 32'b10);

    // Back-to-back with in_valid and out_ready held high.
    @(posedge clk);
    #1;
    exp_q.push_back({16'd16, 16'd16});
    exp_q.push_back({16'd16, 16'd16});
    bus.in_valid = 1'b1;
    seen = 1'b0;
    t1 = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.out_valid) begin seen = 1'b1; t1 = cyc; break; end
    end
    chk("b2b_first_valid", 32'(seen), 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin seen = 1'b1; break; end
    end
    chk("b2b_ready_again", 32'(seen), 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    seen = 1'b0;
    t2 = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.out_valid) begin seen = 1'b1; t2 = cyc; break; end
    end
    chk("b2b_second_valid", 32'(seen), 32'd1);
    chk("b2b_period", 32'(t2 - t1), 32'd20);
    @(posedge clk);
    #1;

    // Abort at step 9: previous results (16) must be wiped, no output follows.
    start_run(16'd0, 16'd0, 1'b0, acc);
    repeat (8) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_state", 32'({bus.in_ready, bus.busy, bus.out_valid}), 32'b100);
    chk("abort_out_27", 32'($unsigned(bus.out_27)), 32'd0);
    chk("abort_out_28", 32'($unsigned(bus.out_28)), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_check(16'd0, 16'd0, "abort_coef_cleared");
    load_all(16'd256);
    run_check(16'd14, 16'd14, "abort_reload");

    repeat (5) @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/arf_sched.md
# arf_sched

Resource-shared sequencer that evaluates the 28-operation ARF data-flow graph on one shared multiplier and one shared adder. The graph has 16 multiplies and 12 adds. The block accepts one input sample set with a valid/ready handshake and steps the operations through a fixed 18-cycle schedule. It then presents out_27/out_28 with a valid/ready handshake. The 16 multiplier coefficients are held in a register file loaded through a write port, so this is the area-minimal counterpart of the fully parallel ARF datapath.

## Interface
- W, 16: data and coefficient width, two's complement.
- FRAC, 8: coefficient fractional bits. Product = (a*b) >>> FRAC (arithmetic, floor), truncated to low W bits.
- clk  in  1  clock; single clock domain.
- rst_n  in  1  reset, asynchronous, active-low.
- in_1..in_8, in_13, in_14  in  W each  sample operands (in_13/in_14 are the second operands of adders 13/14).
- in_valid  in  1  sample set offered.
- in_ready  out  1  high only in IDLE.
- coef_we  in  1  coefficient write strobe.
- coef_addr  in  4  0..7 → mults 1..8; 8..11 → mults 15..18; 12..15 → mults 21..24.
- coef_data  in  W  coefficient value.
- busy  out  1  high in RUN or DONE.
- out_27, out_28  out  W each  results, held stable while out_valid.
- out_valid  out  1  results available.
- out_ready  in  1  consumer accepts results.

## Operation
- Graph:
  - m_k = in_k*c_k for k=1..8.
  - a9=m1+m2, a10=m3+m4, a11=m5+m6, a12=m7+m8.
  - a13=a9+in_13, a14=a10+in_14.
  - m15=a13*c15, m16=a14*c16, m17=a13*c17, m18=a14*c18.
  - a19=m15+m16, a20=m17+m18.
  - m21=a19*c21, m22=a19*c22, m23=a20*c23, m24=a20*c24.
  - a25=m21+m22, a26=m23+m24.
  - out_27=a25+a11, out_28=a26+a12.
- Adds wrap modulo 2^W. Both operators are combinational; the result is registered at the end of the step, so it is usable in the next step.
- FSM: IDLE → RUN on in_valid&in_ready. Inputs are captured at that edge and step counter s=1.
- RUN → DONE after step 18. DONE → IDLE on out_valid&out_ready.
- Fixed schedule, one multiply and at most one add per step:
  - s1 m1; s2 m2; s3 m3,a9; s4 m4,a13; s5 m5,a10; s6 m6,a14.
  - s7 m7,a11; s8 m8; s9 m15,a12; s10 m16; s11 m17; s12 m18,a19.
  - s13 m21,a20; s14 m22; s15 m23,a25; s16 m24,a27; s17 a26; s18 a28.
- Coefficient writes take effect only when not busy (IDLE). Writes while busy are dropped.
- A write coinciding with the accept edge is applied, and the run uses the new value.
- Reset values:
  - state IDLE, s=0; in_ready=1 (combinational from state).
  - busy=0, out_valid=0.
  - out_27/out_28=0; all coefficients and intermediate registers 0.
- Reset mid-run or in DONE aborts immediately. No output is produced and coefficients return to 0.

## Timing
- Accept edge E0. Steps occupy the 18 cycles that follow. out_valid rises at edge E18.
- Results are held until out_ready. The handshake edge returns to IDLE, and in_ready is high the next cycle.
- Minimum sample period is 20 cycles (out_ready and in_valid tied high).
- in_valid while busy is ignored; the producer must hold it.
- out_27/out_28 do not change while out_valid=1.

## Test plan
- Reset, then in_valid=1 with any inputs → out_27=out_28=0 at E18 (all coefficients 0).
- FRAC=8, all 16 coefficients 256 (1.0), all inputs 1 → out_valid at E18, out_27=14, out_28=14. in_ready low E1..E19.
- FRAC=8, c1=128, in_1=-3, other coefficients 0, in_13=in_14=0 → m1=-2 (floor), so out_27=0. Also c5=c6=256, in_5=7, in_6=-9 → out_27=-2.
- coef_we to addr 0 at E5 of a run, then a second run with unit coefficients → the first run is unaffected and the write is dropped (c1 keeps its old value in the second run).
- out_ready held low 10 cycles after E18 → out_valid and values stable. Raise out_ready → IDLE the next cycle. Back-to-back runs have a 20-cycle period.
- rst_n pulsed low at step 9 → outputs 0 immediately and FSM IDLE. A new run with unit coefficients reloaded gives correct results.
